// File: rtl/dac_pkg.sv
// Shared definitions for the DAC write arbiter: FSM encoding, data width and
// the default abort limit.
package dac_pkg;

    localparam int DAC_W           = 12;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible bit strictly after rr_last,
// wrapping around, so rr_last itself has lowest priority.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int GW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [GW-1:0]    rr_last,
    output logic [GW-1:0]    winner,
    output logic             valid
);

    function automatic logic [GW-1:0] idx_at(input logic [GW-1:0] last, input int off);
        return GW'((int'(last) + off) % N_REQ);
    endfunction

    // Scan from the farthest offset down so the nearest eligible bit is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (eligible[idx_at(rr_last, off)]) begin
                winner = idx_at(rr_last, off);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter sharing one serial DAC writer among N_REQ requesters:
// grants, strobes set, waits out busy, enforces a post-write gap and aborts on timeout.
module dac_write_arbiter
    import dac_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  MIN_GAP = 0,
    parameter int  TIMEOUT = DEFAULT_TIMEOUT,
    localparam int GW      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [DAC_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [GW-1:0]          grant_id,
    output logic                   active,
    output logic                   err_timeout,
    input  logic                   clr_err,
    output logic                   dac_set,
    output logic [DAC_W-1:0]       dac_val,
    input  logic                   dac_busy
);

    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int GAPW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    state_e             state_q;
    logic [N_REQ-1:0]   ack_q;
    logic [GW-1:0]      grant_q;
    logic               active_q;
    logic               err_q;
    logic               set_q;
    logic [DAC_W-1:0]   val_q;
    logic [GW-1:0]      rr_last_q;
    logic [TW-1:0]      timer_q;
    logic [GAPW-1:0]    gap_q;

    logic [DAC_W-1:0]   slot [N_REQ];
    logic [N_REQ-1:0]   eligible;
    logic [GW-1:0]      pick_id;
    logic               pick_valid;
    logic               timer_expired;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        assign slot[gi] = req_data[DAC_W*gi +: DAC_W];
    end

    // A requester seeing its ack this cycle must not win again immediately.
    assign eligible      = req & ~ack_q;
    assign timer_expired = ((state_q == ISSUE) || (state_q == WAIT_DONE)) &&
                           (timer_q == TW'(TIMEOUT - 1));

    rr_picker #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_picker (
        .eligible (eligible),
        .rr_last  (rr_last_q),
        .winner   (pick_id),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            grant_q   <= '0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
            set_q     <= 1'b0;
            val_q     <= '0;
            rr_last_q <= GW'(N_REQ - 1);
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            ack_q <= '0;
            if (clr_err) begin
                err_q <= 1'b0;
            end
            if (timer_expired) begin
                set_q          <= 1'b0;
                err_q          <= 1'b1;
                ack_q[grant_q] <= 1'b1;
                active_q       <= 1'b0;
                timer_q        <= '0;
                state_q        <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pick_valid && !dac_busy) begin
                            grant_q   <= pick_id;
                            val_q     <= slot[pick_id];
                            active_q  <= 1'b1;
                            set_q     <= 1'b1;
                            rr_last_q <= pick_id;
                            timer_q   <= '0;
                            state_q   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (dac_busy) begin
                            set_q   <= 1'b0;
                            timer_q <= '0;
                            state_q <= WAIT_DONE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        if (!dac_busy) begin
                            ack_q[grant_q] <= 1'b1;
                            active_q       <= 1'b0;
                            timer_q        <= '0;
                            gap_q          <= '0;
                            state_q        <= (MIN_GAP > 0) ? GAP : IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_q == GAPW'(MIN_GAP - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ack         = ack_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign err_timeout = err_q;
    assign dac_set     = set_q;
    assign dac_val     = val_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter: three instances (no gap, 50-cycle gap,
// dead writer with short timeout) each driving a simple busy-cycle writer model.
module tb_dac_write_arbiter;
    import dac_pkg::*;

    localparam int WLEN = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0]  a_req = '0, b_req = '0, c_req = '0;
    logic [47:0] a_data = '0, b_data = '0, c_data = '0;
    logic        a_clr = 1'b0, b_clr = 1'b0, c_clr = 1'b0;
    logic [3:0]  a_ack, b_ack, c_ack;
    logic [1:0]  a_gid, b_gid, c_gid;
    logic        a_active, b_active, c_active;
    logic        a_err, b_err, c_err;
    logic        a_set, b_set, c_set;
    logic [11:0] a_val, b_val, c_val;

    // Writer model: busy rises the cycle after set, lasts WLEN cycles; channel 2 never responds.
    logic        w_busy   [3] = '{1'b0, 1'b0, 1'b0};
    int          w_cnt    [3] = '{0, 0, 0};
    int          w_writes [3] = '{0, 0, 0};
    logic [11:0] w_word   [3];
    logic        w_set    [3];
    logic [11:0] w_src    [3];
    logic [3:0]  acks     [3];

    assign w_set[0] = a_set;  assign w_set[1] = b_set;  assign w_set[2] = c_set;
    assign w_src[0] = a_val;  assign w_src[1] = b_val;  assign w_src[2] = c_val;
    assign acks[0]  = a_ack;  assign acks[1]  = b_ack;  assign acks[2]  = c_ack;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_busy[i]) begin
                if (w_cnt[i] == 0) w_busy[i] <= 1'b0;
                else               w_cnt[i]  <= w_cnt[i] - 1;
            end else if (w_set[i] && i != 2) begin
                w_busy[i]   <= 1'b1;
                w_cnt[i]    <= WLEN - 1;
                w_word[i]   <= w_src[i];
                w_writes[i] <= w_writes[i] + 1;
            end
        end
    end

    dac_write_arbiter #(.N_REQ(4), .MIN_GAP(0), .TIMEOUT(1024)) u_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .req_data(a_data), .ack(a_ack),
        .grant_id(a_gid), .active(a_active), .err_timeout(a_err), .clr_err(a_clr),
        .dac_set(a_set), .dac_val(a_val), .dac_busy(w_busy[0]));

    dac_write_arbiter #(.N_REQ(4), .MIN_GAP(50), .TIMEOUT(1024)) u_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .req_data(b_data), .ack(b_ack),
        .grant_id(b_gid), .active(b_active), .err_timeout(b_err), .clr_err(b_clr),
        .dac_set(b_set), .dac_val(b_val), .dac_busy(w_busy[1]));

    dac_write_arbiter #(.N_REQ(4), .MIN_GAP(0), .TIMEOUT(16)) u_c (
        .clk(clk), .rst_n(rst_n), .req(c_req), .req_data(c_data), .ack(c_ack),
        .grant_id(c_gid), .active(c_active), .err_timeout(c_err), .clr_err(c_clr),
        .dac_set(c_set), .dac_val(c_val), .dac_busy(w_busy[2]));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for any ack on channel w; hist holds busy at the two samples before it.
    task automatic wait_ack(input int w, input int budget, output logic [3:0] got, output logic [1:0] hist);
        logic p1, p2;
        p1 = 1'b0; p2 = 1'b0; got = '0; hist = '0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (acks[w] != 4'd0) begin
                got  = acks[w];
                hist = {p2, p1};
                return;
            end
            p2 = p1;
            p1 = w_busy[w];
        end
    endtask

    initial begin
        logic [3:0]  got;
        logic [1:0]  hist;
        int          n, spur, wb, exp_id;

        #12;
        check("rst_ack",    32'(a_ack),    32'h0);
        check("rst_gid",    32'(a_gid),    32'h0);
        check("rst_active", 32'(a_active), 32'h0);
        check("rst_err",    32'(a_err),    32'h0);
        check("rst_set",    32'(a_set),    32'h0);
        check("rst_val",    32'(a_val),    32'h0);
        tick();
        rst_n = 1'b1;

        // Single request on requester 2
        a_data = {12'h444, 12'hA5C, 12'h222, 12'h111};
        a_req  = 4'b0100;
        tick();
        check("t1_set",    32'(a_set),    32'h1);
        check("t1_gid",    32'(a_gid),    32'h2);
        check("t1_val",    32'(a_val),    32'hA5C);
        check("t1_active", 32'(a_active), 32'h1);
        wait_ack(0, 200, got, hist);
        check("t1_ack",       32'(got),       32'h4);
        check("t1_ack_lat",   32'(hist),      32'h2);
        check("t1_word",      32'(w_word[0]), 32'hA5C);
        a_req = 4'b0000;
        tick();
        check("t1_ack_width", 32'(a_ack), 32'h0);
        repeat (30) tick();
        check("t1_one_write", 32'(w_writes[0]), 32'd1);
        check("t1_idle",      32'(a_active),    32'h0);

        // Restore reset priority, then all four held high
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_data = {12'h400, 12'h300, 12'h200, 12'h100};
        a_req  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            wait_ack(0, 200, got, hist);
            check($sformatf("t2_ack%0d", k),  32'(got),       32'(1 << exp_id));
            check($sformatf("t2_val%0d", k),  32'(a_val),     32'(12'h100 * (exp_id + 1)));
            check($sformatf("t2_word%0d", k), 32'(w_word[0]), 32'(12'h100 * (exp_id + 1)));
            if (k == 4) a_req = 4'b0000;
            tick();
            check($sformatf("t2_width%0d", k), 32'(a_ack), 32'h0);
        end
        repeat (30) tick();
        check("t2_idle", 32'(a_active), 32'h0);

        // Reset while the writer is mid-cycle
        a_req = 4'b0010;
        n = 0;
        while (!(a_active && !a_set && w_busy[0]) && n < 50) begin
            tick();
            n++;
        end
        check("t3_in_wait", 32'(a_gid), 32'h1);
        repeat (3) tick();
        a_req = 4'b0011;
        #2 rst_n = 1'b0;
        #1;
        check("t3_rst_ack",    32'(a_ack),    32'h0);
        check("t3_rst_active", 32'(a_active), 32'h0);
        check("t3_rst_set",    32'(a_set),    32'h0);
        check("t3_rst_gid",    32'(a_gid),    32'h0);
        check("t3_rst_val",    32'(a_val),    32'h0);
        check("t3_busy_left",  32'(w_busy[0]), 32'h1);
        tick();
        rst_n = 1'b1;
        spur = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!w_busy[0]) break;
            if (a_active || a_ack != 4'd0) spur++;
        end
        check("t3_no_grant_busy", 32'(spur), 32'd0);
        n = 0;
        while (!a_set && n < 10) begin
            tick();
            n++;
        end
        check("t3_regrant_set", 32'(a_set), 32'h1);
        check("t3_regrant_gid", 32'(a_gid), 32'h0);
        a_req = 4'b0000;
        wait_ack(0, 200, got, hist);
        check("t3_ack_after_drop", 32'(got), 32'h1);
        repeat (5) tick();

        // Requester 1 raised and withdrawn during another write
        wb = w_writes[0];
        a_req = 4'b0001;
        tick();
        a_req = 4'b0000;
        repeat (5) tick();
        a_req = 4'b0010;
        repeat (3) tick();
        a_req = 4'b0000;
        wait_ack(0, 200, got, hist);
        check("t4_ack0", 32'(got), 32'h1);
        spur = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (a_active || a_ack != 4'd0) spur++;
        end
        check("t4_no_req1_serve", 32'(spur),        32'd0);
        check("t4_writes",        32'(w_writes[0]), 32'(wb + 1));

        // Minimum gap of 50 cycles between ack and next set
        b_data = {12'h0D0, 12'h0C0, 12'h0B0, 12'h0A0};
        b_req  = 4'b0011;
        wait_ack(1, 200, got, hist);
        check("t5_ack0", 32'(got), 32'h1);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (b_set) break;
            n++;
        end
        check("t5_gap",   32'(n),     32'd50);
        check("t5_gid",   32'(b_gid), 32'h1);
        check("t5_val",   32'(b_val), 32'h0B0);
        b_req = 4'b0000;
        wait_ack(1, 200, got, hist);
        check("t5_ack1", 32'(got), 32'h2);

        // Writer never responds: timeout abort and sticky error
        c_data = {12'h0, 12'h0, 12'h0, 12'h777};
        c_req  = 4'b0001;
        n = 0;
        while (!c_set && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (c_set && n < 100) begin
            n++;
            tick();
        end
        check("t6_set_cycles", 32'(n),        32'd16);
        check("t6_ack",        32'(c_ack),    32'h1);
        check("t6_err",        32'(c_err),    32'h1);
        check("t6_active",     32'(c_active), 32'h0);
        c_req = 4'b0000;
        tick();
        check("t6_ack_width", 32'(c_ack), 32'h0);
        repeat (5) tick();
        check("t6_err_sticky", 32'(c_err), 32'h1);
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        check("t6_err_cleared", 32'(c_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
